// File: rtl/scmp_bus_pak.sv
// Shared definitions for SC/MP bus-side blocks.
//   bus_state_t : bus target cycle states
//   FLAG_IX_*   : bit positions of {F_H, F_D, F_I, F_R} within cyc_flags
//   page_sel()  : masked A15..A12 page compare
package scmp_bus_pak;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    RD_WAIT,
    RD_DRIVE,
    WR_WAIT,
    WR_END
  } bus_state_t;

  localparam int FLAG_IX_R = 0;
  localparam int FLAG_IX_I = 1;
  localparam int FLAG_IX_D = 2;
  localparam int FLAG_IX_H = 3;

  // A mask bit of 1 means that page bit must equal the match bit.
  function automatic logic page_sel(input logic [3:0] page,
                                    input logic [3:0] match,
                                    input logic [3:0] mask);
    return ((page ^ match) & mask) == 4'h0;
  endfunction

endpackage

// File: rtl/reg8.sv
// Eight-bit register with load enable and synchronous active-low reset.
//   clk, rst_n : clock, synchronous active-low reset (clears q)
//   en         : load d into q on the rising edge
//   d, q       : data in / registered data out
module reg8 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [7:0] d,
  output logic [7:0] q
);

  always_ff @(posedge clk) begin
    if (!rst_n)  q <= 8'h00;
    else if (en) q <= d;
  end

endmodule

// File: rtl/scmp_bus_target.sv
// SC/MP bus target: decodes the CPU address phase against a masked page,
// turns CPU read/write strobes into a local memory request/acknowledge
// handshake, and stretches the CPU strobe with hold_n until memory answers.
//   clk, rst_n            : clock, synchronous active-low reset
//   addr, D_i             : CPU A11..A0 and data bus ({flags, A15..A12} in ADS_n)
//   ADS_n, RD_n, WR_n     : CPU strobes, active-low
//   D_o, D_oe             : read data to the CPU and its drive enable
//   hold_n                : 0 stretches the current CPU strobe
//   cyc_flags             : {F_H, F_D, F_I, F_R} of the last address phase
//   mem_*                 : local memory request side
module scmp_bus_target
  import scmp_bus_pak::*;
#(
  parameter logic [3:0] PAGE_MATCH = 4'h0,
  parameter logic [3:0] PAGE_MASK  = 4'hF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [11:0] addr,
  input  logic [7:0]  D_i,
  input  logic        ADS_n,
  input  logic        RD_n,
  input  logic        WR_n,
  output logic [7:0]  D_o,
  output logic        D_oe,
  output logic        hold_n,
  output logic [3:0]  cyc_flags,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_wdata,
  output logic        mem_req,
  output logic        mem_we,
  input  logic        mem_ack,
  input  logic [7:0]  mem_rdata
);

  bus_state_t  state, state_n;
  logic        sel, sel_n;
  logic        d_oe_q, d_oe_n;
  logic        hold_n_n;
  logic [3:0]  cyc_flags_n;
  logic [15:0] mem_addr_n;
  logic [7:0]  mem_wdata_n;
  logic        mem_req_n, mem_we_n;
  logic        ads_take;
  logic        load_rd;

  // NOTE: every next-value is defaulted to its current value before the case,
  // so no path through this block leaves a signal unassigned (no latches).
  always_comb begin
    state_n     = state;
    sel_n       = sel;
    d_oe_n      = d_oe_q;
    hold_n_n    = hold_n;
    cyc_flags_n = cyc_flags;
    mem_addr_n  = mem_addr;
    mem_wdata_n = mem_wdata;
    mem_req_n   = mem_req;
    mem_we_n    = mem_we;
    ads_take    = 1'b0;
    load_rd     = 1'b0;

    case (state)
      IDLE: ads_take = !ADS_n;

      ADDR: begin
        if (!sel) begin
          state_n = IDLE;
        end else if (!RD_n) begin
          // Read wins when both strobes are low.
          mem_req_n = 1'b1;
          mem_we_n  = 1'b0;
          hold_n_n  = 1'b0;
          state_n   = RD_WAIT;
        end else if (!WR_n) begin
          mem_wdata_n = D_i;
          mem_req_n   = 1'b1;
          mem_we_n    = 1'b1;
          hold_n_n    = 1'b0;
          state_n     = WR_WAIT;
        end
      end

      // ADS_n is ignored here: the outstanding request always completes.
      RD_WAIT: begin
        if (mem_ack) begin
          load_rd   = 1'b1;
          mem_req_n = 1'b0;
          hold_n_n  = 1'b1;
          d_oe_n    = 1'b1;
          state_n   = RD_DRIVE;
        end
      end

      RD_DRIVE: begin
        if (!ADS_n) begin
          ads_take = 1'b1;
        end else if (RD_n) begin
          d_oe_n  = 1'b0;
          state_n = IDLE;
        end
      end

      WR_WAIT: begin
        if (mem_ack) begin
          mem_req_n = 1'b0;
          mem_we_n  = 1'b0;
          hold_n_n  = 1'b1;
          state_n   = WR_END;
        end
      end

      WR_END: begin
        if (!ADS_n)    ads_take = 1'b1;
        else if (WR_n) state_n  = IDLE;
      end

      default: state_n = IDLE;
    endcase

    // Address phase: shared by every state that accepts a new cycle.
    if (ads_take) begin
      mem_addr_n             = {D_i[3:0], addr};
      cyc_flags_n[FLAG_IX_R] = D_i[4];
      cyc_flags_n[FLAG_IX_I] = D_i[5];
      cyc_flags_n[FLAG_IX_D] = D_i[6];
      cyc_flags_n[FLAG_IX_H] = D_i[7];
      sel_n                  = page_sel(D_i[3:0], PAGE_MATCH, PAGE_MASK);
      d_oe_n                 = 1'b0;
      state_n                = ADDR;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      sel       <= 1'b0;
      d_oe_q    <= 1'b0;
      hold_n    <= 1'b1;
      cyc_flags <= 4'h0;
      mem_addr  <= 16'h0000;
      mem_wdata <= 8'h00;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
    end else begin
      state     <= state_n;
      sel       <= sel_n;
      d_oe_q    <= d_oe_n;
      hold_n    <= hold_n_n;
      cyc_flags <= cyc_flags_n;
      mem_addr  <= mem_addr_n;
      mem_wdata <= mem_wdata_n;
      mem_req   <= mem_req_n;
      mem_we    <= mem_we_n;
    end
  end

  reg8 u_rd_data (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (load_rd),
    .d     (mem_rdata),
    .q     (D_o)
  );

  // Gating with WR_n guarantees the target never fights a CPU write.
  assign D_oe = d_oe_q & WR_n;

endmodule

// File: tb/tb_scmp_bus_target.sv
// Self-checking bench for scmp_bus_target: directed bus scenarios followed by
// randomized read/write transactions checked against a transaction-level model.
module tb_scmp_bus_target;

  localparam logic [3:0] MATCH = 4'h0;
  localparam logic [3:0] MASK  = 4'h5;

  logic        clk;
  logic        rst_n;
  logic [11:0] addr;
  logic [7:0]  D_i;
  logic        ADS_n, RD_n, WR_n;
  logic [7:0]  D_o;
  logic        D_oe;
  logic        hold_n;
  logic [3:0]  cyc_flags;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_req, mem_we;
  logic        mem_ack;
  logic [7:0]  mem_rdata;

  int n_checks = 0;
  int n_fail   = 0;

  scmp_bus_target #(.PAGE_MATCH(MATCH), .PAGE_MASK(MASK)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .addr      (addr),
    .D_i       (D_i),
    .ADS_n     (ADS_n),
    .RD_n      (RD_n),
    .WR_n      (WR_n),
    .D_o       (D_o),
    .D_oe      (D_oe),
    .hold_n    (hold_n),
    .cyc_flags (cyc_flags),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_ack   (mem_ack),
    .mem_rdata (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Page decode model: every masked bit must agree with the match value.
  function automatic bit model_hit(input logic [3:0] page);
    bit h = 1'b1;
    for (int i = 0; i < 4; i++)
      if (MASK[i] && (page[i] != MATCH[i])) h = 1'b0;
    return h;
  endfunction

  task automatic address_phase(input logic [3:0] p, input logic [3:0] f, input logic [11:0] a);
    ADS_n = 1'b0;
    D_i   = {f, p};
    addr  = a;
    tick();
    ADS_n = 1'b1;
    check("ads_mem_addr", mem_addr, {p, a});
    check("ads_flags", cyc_flags, f);
    check("ads_req", mem_req, 0);
    check("ads_hold", hold_n, 1);
  endtask

  task automatic read_tx(input logic [3:0] p, input logic [3:0] f, input logic [11:0] a,
                         input int gap, input int waits, input logic [7:0] rd, input bit release_rd);
    int hold_cycles;
    address_phase(p, f, a);
    repeat (gap) begin
      tick();
      check("rd_gap_req", mem_req, 0);
    end
    RD_n = 1'b0;
    tick();
    if (!model_hit(p)) begin
      repeat (2) begin
        check("rd_miss_req", mem_req, 0);
        check("rd_miss_hold", hold_n, 1);
        check("rd_miss_oe", D_oe, 0);
        tick();
      end
      RD_n = 1'b1;
      tick();
      return;
    end
    check("rd_req", mem_req, 1);
    check("rd_we", mem_we, 0);
    check("rd_oe_wait", D_oe, 0);
    hold_cycles = (hold_n == 1'b0) ? 1 : 0;
    for (int w = 0; w < waits; w++) begin
      tick();
      check("rd_wait_req", mem_req, 1);
      check("rd_wait_addr", mem_addr, {p, a});
      if (hold_n == 1'b0) hold_cycles++;
    end
    mem_ack   = 1'b1;
    mem_rdata = rd;
    tick();
    mem_ack   = 1'b0;
    mem_rdata = 8'($urandom);
    check("rd_hold_cycles", hold_cycles, waits + 1);
    check("rd_oe", D_oe, 1);
    check("rd_data", D_o, rd);
    check("rd_req_drop", mem_req, 0);
    check("rd_hold_rel", hold_n, 1);
    tick();
    check("rd_drive_oe", D_oe, 1);
    check("rd_drive_data", D_o, rd);
    if (release_rd) begin
      RD_n = 1'b1;
      tick();
      check("rd_end_oe", D_oe, 0);
    end
  endtask

  task automatic write_tx(input logic [3:0] p, input logic [3:0] f, input logic [11:0] a,
                          input int gap, input int waits, input logic [7:0] wd);
    address_phase(p, f, a);
    repeat (gap) begin
      tick();
      check("wr_gap_req", mem_req, 0);
    end
    WR_n = 1'b0;
    D_i  = wd;
    tick();
    if (!model_hit(p)) begin
      repeat (2) begin
        check("wr_miss_req", mem_req, 0);
        check("wr_miss_we", mem_we, 0);
        check("wr_miss_hold", hold_n, 1);
        tick();
      end
      WR_n = 1'b1;
      tick();
      return;
    end
    check("wr_req", mem_req, 1);
    check("wr_we", mem_we, 1);
    check("wr_data", mem_wdata, wd);
    check("wr_hold", hold_n, 0);
    check("wr_oe", D_oe, 0);
    for (int w = 0; w < waits; w++) begin
      tick();
      check("wr_wait_req", mem_req, 1);
      check("wr_wait_oe", D_oe, 0);
    end
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    check("wr_req_drop", mem_req, 0);
    check("wr_we_drop", mem_we, 0);
    check("wr_hold_rel", hold_n, 1);
    check("wr_end_oe", D_oe, 0);
    WR_n = 1'b1;
    tick();
    check("wr_idle_req", mem_req, 0);
  endtask

  initial begin
    rst_n = 1'b0;
    ADS_n = 1'b1; RD_n = 1'b1; WR_n = 1'b1;
    addr = '0; D_i = '0; mem_ack = 1'b0; mem_rdata = 8'h5E;
    tick();
    tick();
    check("rst_do", D_o, 0);
    check("rst_oe", D_oe, 0);
    check("rst_hold", hold_n, 1);
    check("rst_flags", cyc_flags, 0);
    check("rst_addr", mem_addr, 0);
    check("rst_wdata", mem_wdata, 0);
    check("rst_req", mem_req, 0);
    check("rst_we", mem_we, 0);
    rst_n = 1'b1;
    tick();

    // Read hit with two extra wait cycles (ack on the third RD_WAIT cycle).
    read_tx(4'h0, 4'h1, 12'h123, 0, 2, 8'hA5, 1'b1);
    // Write hit with immediate acknowledge.
    write_tx(4'h2, 4'h0, 12'hFFF, 0, 0, 8'h3C);
    // Misses on a compared bit, read and write.
    read_tx(4'h1, 4'h0, 12'h055, 0, 1, 8'h00, 1'b1);
    write_tx(4'h4, 4'h0, 12'h066, 1, 0, 8'h81);

    // ADS_n and WR_n together: only the address phase is taken.
    ADS_n = 1'b0; WR_n = 1'b0; D_i = 8'hA2; addr = 12'h010;
    tick();
    ADS_n = 1'b1;
    check("aw_addr", mem_addr, 16'h2010);
    check("aw_flags", cyc_flags, 4'hA);
    check("aw_req", mem_req, 0);
    D_i = 8'h99;
    tick();
    check("aw_req_wr", mem_req, 1);
    check("aw_we", mem_we, 1);
    check("aw_wdata", mem_wdata, 8'h99);
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    check("aw_done", mem_req, 0);
    WR_n = 1'b1;
    tick();

    // Both strobes low in ADDR: a read, with D_oe held off while WR_n is low.
    address_phase(4'h0, 4'h0, 12'h0AA);
    RD_n = 1'b0; WR_n = 1'b0;
    tick();
    check("rw_req", mem_req, 1);
    check("rw_we", mem_we, 0);
    mem_ack = 1'b1; mem_rdata = 8'h77;
    tick();
    mem_ack = 1'b0;
    check("rw_data", D_o, 8'h77);
    check("rw_oe_wr_low", D_oe, 0);
    WR_n = 1'b1;
    #1;
    check("rw_oe_wr_high", D_oe, 1);
    RD_n = 1'b1;
    tick();
    check("rw_end_oe", D_oe, 0);

    // ADS_n during RD_WAIT is ignored.
    address_phase(4'h0, 4'h0, 12'h321);
    RD_n = 1'b0;
    tick();
    check("ign_req", mem_req, 1);
    ADS_n = 1'b0; D_i = 8'hF8; addr = 12'hEEE;
    tick();
    ADS_n = 1'b1;
    check("ign_addr", mem_addr, 16'h0321);
    check("ign_flags", cyc_flags, 0);
    check("ign_req_held", mem_req, 1);
    mem_ack = 1'b1; mem_rdata = 8'h11;
    tick();
    mem_ack = 1'b0;
    check("ign_data", D_o, 8'h11);
    check("ign_oe", D_oe, 1);
    RD_n = 1'b1;
    tick();

    // Back-to-back: new address phase while RD_DRIVE still has RD_n low.
    read_tx(4'h2, 4'h8, 12'h700, 0, 0, 8'hC3, 1'b0);
    ADS_n = 1'b0; D_i = 8'h38; addr = 12'h456;
    tick();
    ADS_n = 1'b1;
    check("b2b_addr", mem_addr, 16'h8456);
    check("b2b_flags", cyc_flags, 4'h3);
    check("b2b_oe", D_oe, 0);
    tick();
    check("b2b_req", mem_req, 1);
    check("b2b_hold", hold_n, 0);
    mem_ack = 1'b1; mem_rdata = 8'h5A;
    tick();
    mem_ack = 1'b0;
    check("b2b_data", D_o, 8'h5A);
    check("b2b_oe_on", D_oe, 1);
    RD_n = 1'b1;
    tick();
    check("b2b_end_oe", D_oe, 0);

    // Reset while a read is waiting on memory.
    address_phase(4'hA, 4'h4, 12'h777);
    RD_n = 1'b0;
    tick();
    check("mrst_req_before", mem_req, 1);
    tick();
    rst_n = 1'b0;
    tick();
    check("mrst_req", mem_req, 0);
    check("mrst_hold", hold_n, 1);
    check("mrst_oe", D_oe, 0);
    check("mrst_do", D_o, 0);
    check("mrst_addr", mem_addr, 0);
    rst_n = 1'b1; RD_n = 1'b1;
    mem_ack = 1'b1; mem_rdata = 8'hEE;
    tick();
    mem_ack = 1'b0;
    check("mrst_late_ack_oe", D_oe, 0);
    check("mrst_late_ack_do", D_o, 0);
    RD_n = 1'b0;
    tick();
    check("mrst_idle_req", mem_req, 0);
    RD_n = 1'b1;
    tick();

    // Randomized transactions against the model.
    for (int t = 0; t < 40; t++) begin
      logic [3:0]  p, f;
      logic [11:0] a;
      logic [7:0]  d;
      int gap, waits;
      p = 4'($urandom_range(0, 15));
      f = 4'($urandom_range(0, 15));
      a = 12'($urandom_range(0, 4095));
      d = 8'($urandom_range(0, 255));
      gap   = $urandom_range(0, 2);
      waits = $urandom_range(0, 3);
      if ($urandom_range(0, 3) == 0) begin
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        check("stray_ack_req", mem_req, 0);
        check("stray_ack_oe", D_oe, 0);
        check("stray_ack_hold", hold_n, 1);
      end
      if ($urandom_range(0, 1) == 1) read_tx(p, f, a, gap, waits, d, 1'b1);
      else                           write_tx(p, f, a, gap, waits, d);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
